// File: rtl/cache_types_package.sv
// Shared cache types: the set line layout and the SRAM handshake state.
package cache_types_package;
  localparam int WAYS  = 2;
  localparam int MRU   = $clog2(WAYS);
  localparam int TAG_W = 26;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [2:0]       idx;
    logic             blkoff;
    logic [1:0]       bytoff;
  } dcachef_t;

  typedef struct packed {
    logic             v;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    word_t [1:0]      data;
  } cache_way_t;

  typedef struct packed {
    cache_way_t [WAYS-1:0] set;
    logic [MRU-1:0]        mru;
  } cacheline_t;

  localparam int LINE_W = $bits(cacheline_t);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10
  } sram_state_t;
endpackage

// File: rtl/cache_sram_array.sv
// Per-set line storage: async clear, synchronous write, combinational read on one port.
module cache_sram_array
  import cache_types_package::*;
#(
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wen,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) mem[i] <= '0;
    end else if (wen) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/cache_sram.sv
// Variable-latency set storage behind the dcache controller.
// state  | meaning
// FREE   | idle, accepting a new request
// BUSY   | latency countdown on latched op
// ACCESS | one-cycle completion, cacheline valid
module cache_sram
  import cache_types_package::*;
#(
  parameter int SETS    = 8,
  parameter int IDX_W   = $clog2(SETS),
  parameter int ACC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              sramREN,
  input  logic              sramWEN,
  input  logic [IDX_W-1:0]  sramaddr,
  input  logic [LINE_W-1:0] ramstore,
  output logic [LINE_W-1:0] cacheline,
  output sram_state_t       sramstate,
  output logic [CNT_W-1:0]  acc_count
);
  localparam int CW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  sram_state_t       state, next_state;
  logic [CW-1:0]     cnt, next_cnt;
  logic [IDX_W-1:0]  addr_q, op_addr;
  logic              wr_q, op_wr;
  logic [LINE_W-1:0] store_q, op_store, arr_rdata;
  logic              req, accept, enter_acc, arr_wen;

  assign req    = sramREN | sramWEN;
  assign accept = (state == FREE) && req;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FREE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      FREE: begin
        if (req) begin
          next_cnt   = CW'(ACC_LAT - 1);
          next_state = (ACC_LAT == 1) ? ACCESS : BUSY;
        end
      end
      BUSY: begin
        next_cnt = cnt - CW'(1);
        if (cnt == CW'(1)) next_state = ACCESS;
      end
      ACCESS:  next_state = FREE;
      default: next_state = FREE;
    endcase
  end

  // With ACC_LAT = 1 the op completes on the accepting edge, so live inputs feed the array.
  always_comb begin
    sramstate = state;
    enter_acc = (next_state == ACCESS) && (state != ACCESS);
    op_addr   = (state == FREE) ? sramaddr : addr_q;
    op_wr     = (state == FREE) ? sramWEN  : wr_q;
    op_store  = (state == FREE) ? ramstore : store_q;
    arr_wen   = enter_acc && op_wr;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      store_q   <= '0;
      cacheline <= '0;
      acc_count <= '0;
    end else begin
      if (accept) begin
        addr_q <= sramaddr;
        wr_q   <= sramWEN;
        if (sramWEN) store_q <= ramstore;
      end
      if (enter_acc) begin
        cacheline <= op_wr ? op_store : arr_rdata;
        acc_count <= acc_count + CNT_W'(1);
      end
    end
  end

  cache_sram_array #(.SETS(SETS), .IDX_W(IDX_W)) u_array (
    .CLK   (CLK),
    .nRST  (nRST),
    .wen   (arr_wen),
    .addr  (op_addr),
    .wdata (op_store),
    .rdata (arr_rdata)
  );
endmodule
